// File: rtl/lsu_bus_master_if.sv
// rtl/lsu_bus_master_if.sv - pipeline request, writeback and data-bus signals of the load/store unit
interface lsu_bus_master_if;
    // Pipeline request side
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign_ext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        req_ready;
    logic        stall;

    // Writeback and exception side
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;

    // Data bus side
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    // The load/store unit itself
    modport master (
        input  req_valid, req_we, req_size, req_sign_ext, req_addr, req_wdata, req_rd,
        output req_ready, stall,
        output wb_valid, wb_rd, wb_data, misalign,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    // The pipeline and memory system around it
    modport slave (
        output req_valid, req_we, req_size, req_sign_ext, req_addr, req_wdata, req_rd,
        input  req_ready, stall,
        input  wb_valid, wb_rd, wb_data, misalign,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - single-outstanding load/store unit driving a request/grant/rvalid data bus
module lsu_bus_master (
    input  logic             clk,
    input  logic             rst_n,
    lsu_bus_master_if.master lsu
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_q;

    // Fields of the accepted access that are still needed after the bus phase
    logic        we_q;
    logic        sign_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q;

    // Registered bus and writeback outputs
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic        misalign_q;

    // Values derived from the incoming request or the returning read data
    logic        aligned_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_sh_d;
    logic [31:0] load_d;

    // Alignment check, byte enables and lane-replicated store data for the presented request
    always_comb begin
        aligned_d = 1'b0;
        be_d      = 4'b0000;
        wdata_d   = 32'd0;
        case (lsu.req_size)
            2'b00: begin
                aligned_d = 1'b1;
                be_d      = 4'b0001 << lsu.req_addr[1:0];
                wdata_d   = {4{lsu.req_wdata[7:0]}};
            end
            2'b01: begin
                aligned_d = ~lsu.req_addr[0];
                be_d      = lsu.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d   = {2{lsu.req_wdata[15:0]}};
            end
            2'b10: begin
                aligned_d = (lsu.req_addr[1:0] == 2'b00);
                be_d      = 4'b1111;
                wdata_d   = lsu.req_wdata;
            end
            default: begin
                aligned_d = 1'b0;
                be_d      = 4'b0000;
                wdata_d   = 32'd0;
            end
        endcase
        // Loads put nothing on the write data lines
        if (!lsu.req_we) begin
            wdata_d = 32'd0;
        end
    end

    // Load data: move the addressed lane down to bit 0, then zero- or sign-extend
    always_comb begin
        rdata_sh_d = lsu.bus_rdata >> {lane_q, 3'b000};
        load_d     = lsu.bus_rdata;
        case (size_q)
            2'b00:   load_d = {{24{sign_q & rdata_sh_d[7]}}, rdata_sh_d[7:0]};
            2'b01:   load_d = {{16{sign_q & rdata_sh_d[15]}}, rdata_sh_d[15:0]};
            default: load_d = lsu.bus_rdata;
        endcase
    end

    // Transaction FSM: accept or reject in IDLE, request until granted, wait for the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            sign_q      <= 1'b0;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            rd_q        <= 5'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            misalign_q  <= 1'b0;
        end else begin
            // Writeback and misalign are single-cycle pulses
            wb_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lsu.req_valid) begin
                        if (aligned_d) begin
                            we_q        <= lsu.req_we;
                            sign_q      <= lsu.req_sign_ext;
                            size_q      <= lsu.req_size;
                            lane_q      <= lsu.req_addr[1:0];
                            rd_q        <= lsu.req_rd;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= lsu.req_we;
                            bus_addr_q  <= {lsu.req_addr[31:2], 2'b00};
                            bus_be_q    <= be_d;
                            bus_wdata_q <= wdata_d;
                            state_q     <= REQ;
                        end else begin
                            misalign_q  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (lsu.bus_gnt) begin
                        bus_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lsu.bus_rvalid) begin
                        state_q <= IDLE;
                        // A store's rvalid is only the write acknowledge
                        if (!we_q) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= load_d;
                        end
                    end
                end
                default: begin
                    bus_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign lsu.req_ready = (state_q == IDLE);
    assign lsu.stall     = (state_q != IDLE);
    assign lsu.wb_valid  = wb_valid_q;
    assign lsu.wb_rd     = wb_rd_q;
    assign lsu.wb_data   = wb_data_q;
    assign lsu.misalign  = misalign_q;
    assign lsu.bus_req   = bus_req_q;
    assign lsu.bus_we    = bus_we_q;
    assign lsu.bus_addr  = bus_addr_q;
    assign lsu.bus_be    = bus_be_q;
    assign lsu.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb/tb_lsu_bus_master.sv - randomized self-checking bench for lsu_bus_master against a transaction-level model
module tb_lsu_bus_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lsu_bus_master_if lsu ();

    lsu_bus_master dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu   (lsu)
    );

    int          n_vec = 0;
    int          n_bad = 0;

    logic [31:0] last_addr;
    logic [31:0] last_be;
    logic [31:0] last_wdata;
    logic [31:0] last_we;
    logic [31:0] last_wb_data;
    logic [31:0] last_wb_rd;
    logic [31:0] last_wb_valid;
    int          req_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("wb_misalign_exclusive", 32'(lsu.wb_valid & lsu.misalign), 32'd0);
    endtask

    // Model: an access of 2**size bytes is legal only when the address is a multiple of its size
    function automatic bit m_aligned(input logic [1:0] size, input logic [31:0] addr);
        int nb;
        if (size == 2'd3) return 1'b0;
        nb = 1 << size;
        return (addr % nb) == 0;
    endfunction

    function automatic logic [31:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int nb;
        nb = 1 << size;
        return ((32'd1 << nb) - 32'd1) << (addr % 4);
    endfunction

    function automatic logic [31:0] m_wdata(input logic we, input logic [1:0] size, input logic [31:0] wdata);
        if (!we) return 32'd0;
        case (size)
            2'd0:    return {24'd0, wdata[7:0]} * 32'h0101_0101;
            2'd1:    return {16'd0, wdata[15:0]} * 32'h0001_0001;
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic sign,
                                           input logic [31:0] addr, input logic [31:0] rdata);
        longint bits;
        longint mask;
        longint v;
        if (size == 2'd2) return rdata;
        bits = 8 * (64'd1 << size);
        mask = (64'd1 << bits) - 1;
        v    = (longint'(rdata) >> (8 * (addr % 4))) & mask;
        if (sign && ((v >> (bits - 1)) & 1) == 1) v = v | ~mask;
        return 32'(v);
    endfunction

    // The pipeline may wiggle the request lines arbitrarily while the unit is busy
    task automatic drive_junk();
        lsu.req_valid    = 1'($urandom);
        lsu.req_we       = 1'($urandom);
        lsu.req_size     = 2'($urandom);
        lsu.req_sign_ext = 1'($urandom);
        lsu.req_addr     = $urandom;
        lsu.req_wdata    = $urandom;
        lsu.req_rd       = 5'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            lsu.req_valid  = 1'b0;
            lsu.bus_gnt    = 1'($urandom);
            lsu.bus_rvalid = 1'($urandom);
            lsu.bus_rdata  = $urandom;
            tick();
            check("idle_bus_req", 32'(lsu.bus_req), 32'd0);
            check("idle_wb_valid", 32'(lsu.wb_valid), 32'd0);
            check("idle_ready", 32'(lsu.req_ready), 32'd1);
        end
        lsu.bus_gnt    = 1'b0;
        lsu.bus_rvalid = 1'b0;
    endtask

    // One complete access: present, bus phase with gnt_dly idle cycles, response after rv_dly cycles
    task automatic do_access(input logic we, input logic [1:0] size, input logic sign,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                             input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        bit ok;
        ok = m_aligned(size, addr);
        last_wb_valid = 32'd0;
        check("accept_ready", 32'(lsu.req_ready), 32'd1);
        lsu.req_valid    = 1'b1;
        lsu.req_we       = we;
        lsu.req_size     = size;
        lsu.req_sign_ext = sign;
        lsu.req_addr     = addr;
        lsu.req_wdata    = wdata;
        lsu.req_rd       = rd;
        tick();
        if (!ok) begin
            lsu.req_valid = 1'b0;
            check("misalign_pulse", 32'(lsu.misalign), 32'd1);
            check("misalign_bus_req", 32'(lsu.bus_req), 32'd0);
            check("misalign_ready", 32'(lsu.req_ready), 32'd1);
            check("misalign_stall", 32'(lsu.stall), 32'd0);
            tick();
            check("misalign_clear", 32'(lsu.misalign), 32'd0);
            check("misalign_bus_req2", 32'(lsu.bus_req), 32'd0);
            check("misalign_ready2", 32'(lsu.req_ready), 32'd1);
            return;
        end
        req_cycles = 0;
        for (int i = 0; i <= gnt_dly; i++) begin
            check("req_bus_req", 32'(lsu.bus_req), 32'd1);
            check("req_stall", 32'(lsu.stall), 32'd1);
            check("req_ready", 32'(lsu.req_ready), 32'd0);
            check("req_bus_we", 32'(lsu.bus_we), 32'(we));
            check("req_bus_addr", lsu.bus_addr, addr & 32'hFFFF_FFFC);
            check("req_bus_be", 32'(lsu.bus_be), m_be(size, addr));
            check("req_bus_wdata", lsu.bus_wdata, m_wdata(we, size, wdata));
            if (lsu.bus_req) req_cycles++;
            last_addr  = lsu.bus_addr;
            last_be    = 32'(lsu.bus_be);
            last_wdata = lsu.bus_wdata;
            last_we    = 32'(lsu.bus_we);
            drive_junk();
            lsu.bus_gnt    = (i == gnt_dly);
            lsu.bus_rvalid = 1'($urandom);
            lsu.bus_rdata  = $urandom;
            tick();
        end
        for (int i = 0; i <= rv_dly; i++) begin
            check("wait_bus_req", 32'(lsu.bus_req), 32'd0);
            check("wait_stall", 32'(lsu.stall), 32'd1);
            check("wait_wb_valid", 32'(lsu.wb_valid), 32'd0);
            drive_junk();
            lsu.bus_gnt    = 1'($urandom);
            lsu.bus_rvalid = (i == rv_dly);
            lsu.bus_rdata  = (i == rv_dly) ? rdata : $urandom;
            tick();
        end
        lsu.req_valid  = 1'b0;
        lsu.bus_gnt    = 1'b0;
        lsu.bus_rvalid = 1'b0;
        check("done_wb_valid", 32'(lsu.wb_valid), 32'(!we));
        check("done_stall", 32'(lsu.stall), 32'd0);
        check("done_ready", 32'(lsu.req_ready), 32'd1);
        check("done_bus_req", 32'(lsu.bus_req), 32'd0);
        check("done_misalign", 32'(lsu.misalign), 32'd0);
        last_wb_valid = 32'(lsu.wb_valid);
        if (!we) begin
            check("wb_rd", 32'(lsu.wb_rd), 32'(rd));
            check("wb_data", lsu.wb_data, m_load(size, sign, addr, rdata));
            last_wb_data = lsu.wb_data;
            last_wb_rd   = 32'(lsu.wb_rd);
        end
    endtask

    initial begin
        lsu.req_valid    = 1'b0;
        lsu.req_we       = 1'b0;
        lsu.req_size     = 2'd0;
        lsu.req_sign_ext = 1'b0;
        lsu.req_addr     = 32'd0;
        lsu.req_wdata    = 32'd0;
        lsu.req_rd       = 5'd0;
        lsu.bus_gnt      = 1'b0;
        lsu.bus_rvalid   = 1'b0;
        lsu.bus_rdata    = 32'd0;
        rst_n            = 1'b0;
        tick();
        tick();
        check("rst_bus_req", 32'(lsu.bus_req), 32'd0);
        check("rst_wb_valid", 32'(lsu.wb_valid), 32'd0);
        check("rst_misalign", 32'(lsu.misalign), 32'd0);
        check("rst_ready", 32'(lsu.req_ready), 32'd1);
        check("rst_stall", 32'(lsu.stall), 32'd0);
        check("rst_bus_addr", lsu.bus_addr, 32'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        // LB from the top byte lane with sign extension
        do_access(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 5'd7, 0, 0, 32'h80FF_FFFF);
        check("lb_bus_addr", last_addr, 32'h0000_1000);
        check("lb_bus_be", last_be, 32'h0000_0008);
        check("lb_wb_data", last_wb_data, 32'hFFFF_FF80);

        // SH to the upper half
        do_access(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 5'd9, 0, 1, 32'hDEAD_BEEF);
        check("sh_bus_be", last_be, 32'h0000_000C);
        check("sh_bus_wdata", last_wdata, 32'hBEEF_BEEF);
        check("sh_bus_we", last_we, 32'd1);
        check("sh_no_wb", last_wb_valid, 32'd0);

        // Misaligned LW
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'd0, 5'd1, 0, 0, 32'd0);

        // LHU with a slow grant
        do_access(1'b0, 2'd1, 1'b0, 32'h0000_4000, 32'd0, 5'd12, 3, 0, 32'h1234_ABCD);
        check("lhu_req_cycles", 32'(req_cycles), 32'd4);
        check("lhu_wb_data", last_wb_data, 32'h0000_ABCD);

        // Back-to-back loads, second presented the cycle the first writes back
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, 5'd3, 0, 0, 32'h1111_1111);
        check("b2b_first_rd", last_wb_rd, 32'd3);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_0014, 32'd0, 5'd4, 0, 0, 32'h2222_2222);
        check("b2b_second_rd", last_wb_rd, 32'd4);
        check("b2b_second_data", last_wb_data, 32'h2222_2222);

        // Reset while waiting for the response, then a stale rvalid
        lsu.req_valid = 1'b1;
        lsu.req_we    = 1'b0;
        lsu.req_size  = 2'd2;
        lsu.req_addr  = 32'h0000_0020;
        lsu.req_rd    = 5'd5;
        tick();
        lsu.req_valid = 1'b0;
        lsu.bus_gnt   = 1'b1;
        tick();
        lsu.bus_gnt   = 1'b0;
        check("rstw_stall_before", 32'(lsu.stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstw_bus_req", 32'(lsu.bus_req), 32'd0);
        check("rstw_bus_we", 32'(lsu.bus_we), 32'd0);
        check("rstw_bus_addr", lsu.bus_addr, 32'd0);
        check("rstw_bus_be", 32'(lsu.bus_be), 32'd0);
        check("rstw_bus_wdata", lsu.bus_wdata, 32'd0);
        check("rstw_wb_valid", 32'(lsu.wb_valid), 32'd0);
        check("rstw_wb_rd", 32'(lsu.wb_rd), 32'd0);
        check("rstw_wb_data", lsu.wb_data, 32'd0);
        check("rstw_misalign", 32'(lsu.misalign), 32'd0);
        check("rstw_ready", 32'(lsu.req_ready), 32'd1);
        check("rstw_stall", 32'(lsu.stall), 32'd0);
        tick();
        rst_n          = 1'b1;
        lsu.bus_rvalid = 1'b1;
        lsu.bus_rdata  = 32'hCAFE_F00D;
        tick();
        lsu.bus_rvalid = 1'b0;
        check("rstw_no_wb", 32'(lsu.wb_valid), 32'd0);
        check("rstw_ready_after", 32'(lsu.req_ready), 32'd1);
        tick();
        check("rstw_no_wb2", 32'(lsu.wb_valid), 32'd0);

        // Random accesses of every size, alignment and latency
        for (int t = 0; t < 200; t++) begin
            do_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
